// File: rtl/booth_mul_sequencer_pkg.sv
// Shared definitions for the Booth multiply sequencer: FSM encodings and
// the radix-2 recode values for the {Q0,Q-1} bit pair.
package booth_mul_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
   localparam logic [1:0] BOOTH_ADD   = 2'b01;
   localparam logic [1:0] BOOTH_SUB   = 2'b10;
   localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// Control-unit <-> multiplier bus. Handshake: start is honoured only while
// busy=0; done is a one-cycle pulse and hi/lo stay valid until the next done or clr.
interface booth_mul_sequencer_if
   import booth_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   state_t           state;

   modport master (
      output start, mcand, mplier,
      input  busy, done, hi, lo, state
   );

   modport slave (
      input  start, mcand, mplier,
      output busy, done, hi, lo, state
   );
endinterface

// File: rtl/booth_mul_sequencer_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the {A,Q,Q-1} triple. Purely combinational.
module booth_step
   import booth_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   // A carries one guard bit so A-M with M = most-negative stays in range.
   assign m_ext = {m[WIDTH-1], m};

   always_comb begin
      sum = a;
      case ({q[0], q_m1})
         BOOTH_ADD: sum = a + m_ext;
         BOOTH_SUB: sum = a - m_ext;
         default:   sum = a;
      endcase
   end

   assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
   assign q_next    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mul_sequencer.sv
// Multi-cycle signed multiplier for MUL: one Booth step per clock through a
// single shared adder, result delivered as hi/lo with a one-cycle done pulse.
module booth_mul_sequencer
   import booth_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic                  clk,
   input logic                  clr,
   booth_mul_sequencer_if.slave bus
);

   state_t           state;
   state_t           state_n;
   logic [WIDTH:0]   a_r;
   logic [WIDTH-1:0] q_r;
   logic             q1_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [CNT_W-1:0] count;

   logic [WIDTH:0]   a_nx;
   logic [WIDTH-1:0] q_nx;
   logic             q1_nx;
   logic             last_step;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a         (a_r),
      .q         (q_r),
      .q_m1      (q1_r),
      .m         (m_r),
      .a_next    (a_nx),
      .q_next    (q_nx),
      .q_m1_next (q1_nx)
   );

   assign last_step = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (clr) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (bus.start) state_n = ST_RUN;
         ST_RUN:  if (last_step) state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // The final step's result goes straight into hi/lo so they change in one go.
   always_ff @(posedge clk) begin
      if (clr) begin
         a_r   <= '0;
         q_r   <= '0;
         q1_r  <= 1'b0;
         m_r   <= '0;
         hi_r  <= '0;
         lo_r  <= '0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  m_r   <= bus.mcand;
                  q_r   <= bus.mplier;
                  a_r   <= '0;
                  q1_r  <= 1'b0;
                  count <= '0;
               end
            end
            ST_RUN: begin
               a_r   <= a_nx;
               q_r   <= q_nx;
               q1_r  <= q1_nx;
               count <= count + 1'b1;
               if (last_step) begin
                  hi_r <= a_nx[WIDTH-1:0];
                  lo_r <= q_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state != ST_IDLE);
   assign bus.done  = (state == ST_DONE);
   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.state = state;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed bench for booth_mul_sequencer: a table of hand-computed products
// plus sequences for ignored start, mid-run clr and back-to-back operation.
module tb_booth_mul_sequencer;
   import booth_mul_sequencer_pkg::*;

   localparam int W = 32;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   cyc_ctr  = 0;
   logic [2*W-1:0] exp_q[$];

   booth_mul_sequencer_if #(.WIDTH(W)) bus ();

   booth_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc_ctr++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!clr && bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc_ctr);
         end else begin
            check("result", {bus.hi, bus.lo}, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      bus.start = 1'b0;
      bus.mcand = '0;
      bus.mplier = '0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc, output int busy_cnt, output bit seen);
      cyc = 1;
      busy_cnt = 0;
      seen = 0;
      while (1) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            seen = 1;
            break;
         end
         if (cyc >= limit) break;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int cyc;
      int busy_cnt;
      bit seen;
      exp_q.push_back({ehi, elo});
      @(negedge clk);
      bus.start = 1'b1;
      bus.mcand = a;
      bus.mplier = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.mcand = ~a;
      bus.mplier = ~b;
      wait_done(100, cyc, busy_cnt, seen);
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_latency"}, 64'(cyc), 64'(W + 1));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
      @(negedge clk);
      check({name, "_idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
      check({name, "_hold"}, {bus.hi, bus.lo}, {ehi, elo});
   endtask

   vec_t vecs[9];

   initial begin
      int cyc;
      int busy_cnt;
      bit seen;
      int d0;
      int t[3];

      vecs[0] = '{"p7x6",      32'd7,          32'd6,          32'h00000000, 32'h0000002A};
      vecs[1] = '{"m3x5",      32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{"minxmin",   32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
      vecs[3] = '{"maxxmax",   32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001};
      vecs[4] = '{"m1xm1",     32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001};
      vecs[5] = '{"zero",      32'h00000000,   32'h12345678,   32'h00000000, 32'h00000000};
      vecs[6] = '{"minx1",     32'h80000000,   32'h00000001,   32'hFFFFFFFF, 32'h80000000};
      vecs[7] = '{"minxm1",    32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000};
      vecs[8] = '{"maxxmin",   32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000};

      bus.start = 1'b0;
      bus.mcand = '0;
      bus.mplier = '0;
      do_reset();
      check("reset_outputs", {62'd0, bus.busy, bus.done}, 64'd0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      check("reset_state", 64'(bus.state), 64'(ST_IDLE));

      for (int i = 0; i < 9; i++)
         run_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // start while busy is ignored
      d0 = done_cnt;
      exp_q.push_back(64'h2A);
      @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'd7; bus.mplier = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(100, cyc, busy_cnt, seen);
      check("ign_done_seen", 64'(seen), 64'd1);
      repeat (40) @(negedge clk);
      check("ign_single_done", 64'(done_cnt - d0), 64'd1);
      check("ign_idle", 64'(bus.busy), 64'd0);

      // clr mid-run aborts with no done
      @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'd7; bus.mplier = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      check("clr_pre_busy", 64'(bus.busy), 64'd1);
      d0 = done_cnt;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      check("clr_hilo", {bus.hi, bus.lo}, 64'd0);
      check("clr_state", 64'(bus.state), 64'(ST_IDLE));
      repeat (40) @(negedge clk);
      check("clr_no_done", 64'(done_cnt - d0), 64'd0);
      run_mul("p2x3", 32'd2, 32'd3, 32'd0, 32'd6);

      // start held high: one result every W+2 cycles
      for (int k = 0; k < 3; k++) exp_q.push_back(64'd1);
      @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'hFFFFFFFF; bus.mplier = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         wait_done(100, cyc, busy_cnt, seen);
         check("held_done_seen", 64'(seen), 64'd1);
         t[k] = cyc_ctr;
      end
      bus.start = 1'b0;
      check("held_period_1", 64'(t[1] - t[0]), 64'(W + 2));
      check("held_period_2", 64'(t[2] - t[1]), 64'(W + 2));
      repeat (40) @(negedge clk);
      check("held_stopped", 64'(bus.busy), 64'd0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
